ddr_sample_streamer: RTL and testbench

- Downstream consumer of the DDR3 MIG user interface in the sound generator.
- Issues read bursts for a contiguous region of packed 16-bit audio samples and buffers the returned 256-bit lines.
- Unpacks each line into 16 samples and presents them to the playback stage on a valid/ready handshake.
- Runs entirely in the ui_clk domain. No write traffic is issued.

---
 rtl/ddr_stream_pkg.sv | 31 +++
 rtl/line_fifo.sv | 75 +++++++
 rtl/line_fifo_chk.sv | 12 +
 rtl/ddr_sample_streamer.sv | 251 +++++++++++++++++++++++++
 tb/tb_ddr_sample_streamer.sv | 338 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ddr_stream_pkg.sv
// Shared constants for the DDR sample streamer: MIG command codes, default
// geometry, streamer state encoding and a saturating counter helper.
package ddr_stream_pkg;

    localparam logic [2:0] CMD_WRITE = 3'b000;
    localparam logic [2:0] CMD_READ  = 3'b001;

    localparam int ADDR_STEP_DEF    = 8;
    localparam int DATA_W_DEF       = 256;
    localparam int SAMPLE_W_DEF     = 16;
    localparam int SAMPLES_PER_LINE = DATA_W_DEF / SAMPLE_W_DEF;

    // Streamer state encoding (kept as plain constants for legacy tools)
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_WAIT_CAL = 3'd1;
    localparam logic [2:0] ST_ISSUE    = 3'd2;
    localparam logic [2:0] ST_DRAIN    = 3'd3;
    localparam logic [2:0] ST_DONE     = 3'd4;

    // Increment that sticks at all-ones instead of wrapping
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        logic [15:0] r;
        if (v == 16'hFFFF) begin
            r = v;
        end else begin
            r = v + 16'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/line_fifo.sv
// Synchronous FIFO with a combinational head (zero-bubble read). Pushes while
// full are dropped, pops while empty are ignored.
module line_fifo
    import ddr_stream_pkg::*;
#(
    parameter int WIDTH = 256,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign full      = (count_r == DEPTH_C);
    assign empty     = (count_r == {CW{1'b0}});
    assign count     = count_r;
    assign pop_data  = mem_r[rd_ptr_r];
    assign do_push_s = push && !full;
    assign do_pop_s  = pop && !empty;

    // Line storage; data needs no reset because empty gates its use
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointers and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    line_fifo_chk u_chk (
        .clk  (clk),
        .rst  (rst),
        .push (push),
        .full (full)
    );

endmodule

// File: rtl/line_fifo_chk.sv
// Simulation checker for line_fifo: a push into a full FIFO means the credit
// accounting upstream is broken.
module line_fifo_chk (
    input logic clk,
    input logic rst,
    input logic push,
    input logic full
);

    push_while_full_a: assert property (@(posedge clk) disable iff (rst) !(push && full));

endmodule

// File: rtl/ddr_sample_streamer.sv
// ddr_sample_streamer: issues MIG read bursts over a contiguous line region,
// buffers returned lines and unpacks them LSB-first into audio samples.
// Build option: define STREAMER_UNDERRUN_CNT_EN to add the underrun_cnt output.
module ddr_sample_streamer
    import ddr_stream_pkg::*;
#(
    parameter int ADDR_W     = 29,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int SAMPLE_W   = SAMPLE_W_DEF,
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_STEP  = ADDR_STEP_DEF
) (
    input  logic                ui_clk,
    input  logic                ui_clk_sync_rst,
    input  logic                init_calib_complete,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [15:0]         num_lines,
    input  logic                loop_en,
    input  logic                stop,
    output logic [ADDR_W-1:0]   app_addr,
    output logic [2:0]          app_cmd,
    output logic                app_en,
    input  logic                app_rdy,
    input  logic [DATA_W-1:0]   app_rd_data,
    input  logic                app_rd_data_valid,
    output logic [SAMPLE_W-1:0] sample_data,
    output logic                sample_valid,
    input  logic                sample_ready,
    output logic                busy,
    output logic                done
`ifdef STREAMER_UNDERRUN_CNT_EN
    ,
    output logic [15:0]         underrun_cnt
`endif
);

    localparam int SPL = DATA_W / SAMPLE_W;
    localparam int IW  = $clog2(SPL);
    localparam int CW  = $clog2(FIFO_DEPTH) + 1;
    localparam logic [ADDR_W-1:0] STEP_L   = ADDR_W'(ADDR_STEP);
    localparam logic [CW:0]       DEPTH_L  = (CW+1)'(FIFO_DEPTH);
    localparam logic [CW-1:0]     OUT_ONE  = CW'(1);
    localparam logic [IW-1:0]     IDX_ONE  = IW'(1);
    localparam logic [IW-1:0]     IDX_LAST = IW'(SPL - 1);

    logic [2:0]          state_r;
    logic                busy_r;
    logic                done_r;
    logic                app_en_r;
    logic [ADDR_W-1:0]   app_addr_r;
    logic [ADDR_W-1:0]   cur_addr_r;
    logic [ADDR_W-1:0]   base_r;
    logic [15:0]         num_r;
    logic [15:0]         lines_left_r;
    logic                loop_r;
    logic                stop_pend_r;
    logic [CW-1:0]       outstanding_r;
    logic [IW-1:0]       idx_r;

    logic [DATA_W-1:0]   head_s;
    logic                fifo_full_s;
    logic                fifo_empty_s;
    logic [CW-1:0]       fifo_count_s;
    logic                push_s;
    logic                pop_s;
    logic                accept_s;
    logic                credit_s;
    logic                stop_req_s;
    logic                last_line_s;
    logic                sample_valid_s;
    logic [SAMPLE_W-1:0] sample_data_s;
    logic [SAMPLE_W-1:0] lane_s [SPL];

    // Returns only count when a read is actually outstanding, so data still
    // in flight across a reset is discarded.
    assign push_s         = app_rd_data_valid && (outstanding_r != {CW{1'b0}});
    assign sample_valid_s = !fifo_empty_s;
    assign pop_s          = sample_valid_s && sample_ready && (idx_r == IDX_LAST);
    assign accept_s       = app_en_r && app_rdy;
    assign credit_s       = (({1'b0, outstanding_r} + {1'b0, fifo_count_s}) < DEPTH_L);
    assign stop_req_s     = stop || stop_pend_r;
    assign last_line_s    = (lines_left_r == 16'd1);

    assign app_addr     = app_addr_r;
    assign app_cmd      = CMD_READ;
    assign app_en       = app_en_r;
    assign sample_valid = sample_valid_s;
    assign sample_data  = sample_data_s;
    assign busy         = busy_r;
    assign done         = done_r;

    line_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_line_fifo (
        .clk       (ui_clk),
        .rst       (ui_clk_sync_rst),
        .push      (push_s),
        .push_data (app_rd_data),
        .pop       (pop_s),
        .pop_data  (head_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .count     (fifo_count_s)
    );

    // Stream control: command issue, address walk, loop reload and drain
    always_ff @(posedge ui_clk or posedge ui_clk_sync_rst) begin
        if (ui_clk_sync_rst) begin
            state_r      <= ST_IDLE;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            app_en_r     <= 1'b0;
            app_addr_r   <= {ADDR_W{1'b0}};
            cur_addr_r   <= {ADDR_W{1'b0}};
            base_r       <= {ADDR_W{1'b0}};
            num_r        <= 16'd0;
            lines_left_r <= 16'd0;
            loop_r       <= 1'b0;
            stop_pend_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start && (num_lines != 16'd0)) begin
                        base_r       <= base_addr;
                        num_r        <= num_lines;
                        loop_r       <= loop_en;
                        cur_addr_r   <= base_addr;
                        lines_left_r <= num_lines;
                        busy_r       <= 1'b1;
                        stop_pend_r  <= 1'b0;
                        state_r      <= ST_WAIT_CAL;
                    end else if (start) begin
                        done_r  <= 1'b1;
                        state_r <= ST_DONE;
                    end
                end
                ST_WAIT_CAL: begin
                    if (init_calib_complete) begin
                        state_r <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (accept_s) begin
                        // A command hands off: advance, and reload or finish
                        app_en_r     <= 1'b0;
                        cur_addr_r   <= cur_addr_r + STEP_L;
                        lines_left_r <= lines_left_r - 16'd1;
                        if (last_line_s && loop_r) begin
                            cur_addr_r   <= base_r;
                            lines_left_r <= num_r;
                        end
                        if ((last_line_s && !loop_r) || stop_req_s) begin
                            stop_pend_r <= 1'b0;
                            state_r     <= ST_DRAIN;
                        end
                    end else if (app_en_r) begin
                        // Pending command must finish before honouring stop
                        if (stop) begin
                            stop_pend_r <= 1'b1;
                        end
                    end else if (stop_req_s) begin
                        stop_pend_r <= 1'b0;
                        state_r     <= ST_DRAIN;
                    end else if (credit_s) begin
                        app_en_r   <= 1'b1;
                        app_addr_r <= cur_addr_r;
                    end
                end
                ST_DRAIN: begin
                    if ((outstanding_r == {CW{1'b0}}) && fifo_empty_s) begin
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        state_r <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    busy_r   <= 1'b0;
                    app_en_r <= 1'b0;
                    state_r  <= ST_IDLE;
                end
            endcase
        end
    end

    // Reads issued but not yet returned
    always_ff @(posedge ui_clk or posedge ui_clk_sync_rst) begin
        if (ui_clk_sync_rst) begin
            outstanding_r <= {CW{1'b0}};
        end else begin
            case ({accept_s, push_s})
                2'b10:   outstanding_r <= outstanding_r + OUT_ONE;
                2'b01:   outstanding_r <= outstanding_r - OUT_ONE;
                default: outstanding_r <= outstanding_r;
            endcase
        end
    end

    // Sample index within the head line; wraps as the line is popped
    always_ff @(posedge ui_clk or posedge ui_clk_sync_rst) begin
        if (ui_clk_sync_rst) begin
            idx_r <= {IW{1'b0}};
        end else if (sample_valid_s && sample_ready) begin
            if (idx_r == IDX_LAST) begin
                idx_r <= {IW{1'b0}};
            end else begin
                idx_r <= idx_r + IDX_ONE;
            end
        end
    end

    // Split the head line into lanes, lane 0 being the least significant
    always_comb begin
        for (int i = 0; i < SPL; i++) begin
            lane_s[i] = head_s[i*SAMPLE_W +: SAMPLE_W];
        end
    end

    // Present the selected lane, zero when nothing is buffered
    always_comb begin
        sample_data_s = {SAMPLE_W{1'b0}};
        if (!fifo_empty_s) begin
            sample_data_s = lane_s[idx_r];
        end else begin
            sample_data_s = {SAMPLE_W{1'b0}};
        end
    end

`ifdef STREAMER_UNDERRUN_CNT_EN
    logic [15:0] underrun_r;

    // Cycles where the consumer wanted data during a stream and none was ready
    always_ff @(posedge ui_clk or posedge ui_clk_sync_rst) begin
        if (ui_clk_sync_rst) begin
            underrun_r <= 16'h0000;
        end else if ((state_r == ST_IDLE) && start) begin
            underrun_r <= 16'h0000;
        end else if (busy_r && sample_ready && !sample_valid_s) begin
            underrun_r <= sat_inc16(underrun_r);
        end
    end

    assign underrun_cnt = underrun_r;
`endif

endmodule

// File: tb/tb_ddr_sample_streamer.sv
// Self-checking bench for ddr_sample_streamer: a MIG read responder with
// configurable latency/app_rdy, a randomized consumer, and a reference model
// that derives expected addresses and samples from the stream parameters.
module tb_ddr_sample_streamer;

    localparam int ADDR_W   = 29;
    localparam int DATA_W   = 256;
    localparam int SAMPLE_W = 16;
    localparam int DEPTH    = 4;
    localparam int STEP     = 8;
    localparam int SPL      = DATA_W / SAMPLE_W;

    logic                ui_clk = 1'b0;
    logic                ui_clk_sync_rst = 1'b1;
    logic                init_calib_complete = 1'b0;
    logic                start = 1'b0;
    logic [ADDR_W-1:0]   base_addr = '0;
    logic [15:0]         num_lines = 16'd0;
    logic                loop_en = 1'b0;
    logic                stop = 1'b0;
    logic [ADDR_W-1:0]   app_addr;
    logic [2:0]          app_cmd;
    logic                app_en;
    logic                app_rdy = 1'b0;
    logic [DATA_W-1:0]   app_rd_data = '0;
    logic                app_rd_data_valid = 1'b0;
    logic [SAMPLE_W-1:0] sample_data;
    logic                sample_valid;
    logic                sample_ready = 1'b0;
    logic                busy;
    logic                done;
`ifdef STREAMER_UNDERRUN_CNT_EN
    logic [15:0]         underrun_cnt;
`endif

    ddr_sample_streamer dut (
        .ui_clk              (ui_clk),
        .ui_clk_sync_rst     (ui_clk_sync_rst),
        .init_calib_complete (init_calib_complete),
        .start               (start),
        .base_addr           (base_addr),
        .num_lines           (num_lines),
        .loop_en             (loop_en),
        .stop                (stop),
        .app_addr            (app_addr),
        .app_cmd             (app_cmd),
        .app_en              (app_en),
        .app_rdy             (app_rdy),
        .app_rd_data         (app_rd_data),
        .app_rd_data_valid   (app_rd_data_valid),
        .sample_data         (sample_data),
        .sample_valid        (sample_valid),
        .sample_ready        (sample_ready),
        .busy                (busy),
        .done                (done)
`ifdef STREAMER_UNDERRUN_CNT_EN
        ,
        .underrun_cnt        (underrun_cnt)
`endif
    );

    always #5 ui_clk = ~ui_clk;

    typedef struct {
        int                due;
        logic [ADDR_W-1:0] addr;
    } ret_t;

    int checks = 0;
    int failures = 0;
    int unsigned seed;
    int cyc = 0;
    int lat = 2;
    int unsigned rdy_pct = 100;
    int unsigned srdy_pct = 100;
    bit rdy_force_low = 1'b0;
    bit srdy_hold = 1'b0;
    logic [ADDR_W-1:0] exp_base = '0;
    int exp_num = 0;
    bit exp_loop = 1'b0;
    int acc_cnt = 0;
    int smp_cnt = 0;
    logic [15:0] uc = 16'd0;
    bit prev_pend = 1'b0;
    logic [ADDR_W-1:0] prev_addr = '0;
    ret_t ret_q[$];
    logic [SAMPLE_W-1:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Memory content: an arbitrary but reproducible sample per (line, lane)
    function automatic logic [SAMPLE_W-1:0] sample_of(input logic [ADDR_W-1:0] a, input int j);
        logic [31:0] h;
        h = {3'b000, a} * 32'h9E37_79B1 + 32'(j) * 32'h0000_1357 + seed;
        return h[31:16] ^ h[15:0];
    endfunction

    task automatic tick;
        @(negedge ui_clk);
    endtask

    task automatic start_stream(input logic [ADDR_W-1:0] b, input int n, input bit lp);
        exp_base = b;
        exp_num  = n;
        exp_loop = lp;
        acc_cnt  = 0;
        smp_cnt  = 0;
        uc       = 16'd0;
        exp_q.delete();
        base_addr = b;
        num_lines = 16'(n);
        loop_en   = lp;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n;
        n = 0;
        while (!done && n < budget) begin
            tick();
            n++;
        end
        check(tag, 64'(done), 64'd1);
        check({tag, "_busy"}, 64'(busy), 64'd0);
    endtask

    task automatic wait_acc(input string tag, input int target, input int budget);
        int n;
        n = 0;
        while (acc_cnt < target && n < budget) begin
            tick();
            n++;
        end
        check(tag, 64'(acc_cnt >= target), 64'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_app_en"}, 64'(app_en), 64'd0);
        check({tag, "_app_cmd"}, 64'(app_cmd), 64'd1);
        check({tag, "_app_addr"}, 64'(app_addr), 64'd0);
        check({tag, "_svalid"}, 64'(sample_valid), 64'd0);
        check({tag, "_sdata"}, 64'(sample_data), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
`ifdef STREAMER_UNDERRUN_CNT_EN
        check({tag, "_underrun"}, 64'(underrun_cnt), 64'd0);
`endif
    endtask

    // MIG responder, consumer and reference model. Inputs change on the falling
    // edge; the handshakes seen here complete on the following rising edge.
    always @(negedge ui_clk) begin
        ret_t r;
        logic [DATA_W-1:0] ln;
        logic [ADDR_W-1:0] ea;
        logic [SAMPLE_W-1:0] es;
        int k;
        cyc++;
        app_rdy = !rdy_force_low && ($urandom_range(99) < rdy_pct);
        sample_ready = !srdy_hold && ($urandom_range(99) < srdy_pct);
        app_rd_data_valid = 1'b0;
        if (ret_q.size() > 0 && ret_q[0].due <= cyc) begin
            r = ret_q.pop_front();
            for (int j = 0; j < SPL; j++) ln[j*SAMPLE_W +: SAMPLE_W] = sample_of(r.addr, j);
            app_rd_data = ln;
            app_rd_data_valid = 1'b1;
        end
        if (!ui_clk_sync_rst) begin
            if (prev_pend) begin
                check("hold_app_en", 64'(app_en), 64'd1);
                check("hold_app_addr", 64'(app_addr), 64'(prev_addr));
            end
            if (app_en && app_rdy) begin
                check("app_cmd", 64'(app_cmd), 64'd1);
                k = (exp_loop && exp_num > 0) ? (acc_cnt % exp_num) : acc_cnt;
                ea = exp_base + ADDR_W'(STEP * k);
                check("app_addr", 64'(app_addr), 64'(ea));
                if (!exp_loop) check("cmd_count", 64'(acc_cnt < exp_num), 64'd1);
                acc_cnt++;
                check("credit", 64'((acc_cnt - smp_cnt / SPL) <= DEPTH), 64'd1);
                ret_q.push_back('{cyc + lat, app_addr});
                for (int j = 0; j < SPL; j++) exp_q.push_back(sample_of(app_addr, j));
            end
            prev_pend = app_en && !app_rdy;
            prev_addr = app_addr;
            if (sample_valid && sample_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_sample", 64'd1, 64'd0);
                end else begin
                    es = exp_q.pop_front();
                    check("sample", 64'(sample_data), 64'(es));
                end
                smp_cnt++;
            end
            if (busy && sample_ready && !sample_valid && uc != 16'hFFFF) uc = uc + 16'd1;
        end else begin
            prev_pend = 1'b0;
            uc = 16'd0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0;
        seed = $urandom;

        // Reset state
        repeat (3) tick();
        check_reset_outputs("reset");
        ui_clk_sync_rst = 1'b0;
        init_calib_complete = 1'b1;
        repeat (2) tick();

        // Basic stream: three lines, immediate app_rdy, two-cycle return
        start_stream(29'h100, 3, 1'b0);
        wait_done("basic_done", 300);
        check("basic_cmds", 64'(acc_cnt), 64'd3);
        check("basic_samples", 64'(smp_cnt), 64'd48);
        check("basic_left", 64'(exp_q.size()), 64'd0);
        tick();
        check("basic_done_pulse", 64'(done), 64'd0);

        // Randomized streams: app_rdy, consumer and latency vary; first one wraps
        for (int t = 0; t < 2; t++) begin
            int n;
            logic [ADDR_W-1:0] b;
            lat = int'($urandom_range(6, 2));
            rdy_pct = 70;
            srdy_pct = 60;
            n = int'($urandom_range(9, 5));
            b = (t == 0) ? 29'h1FFF_FFF0 : (ADDR_W'($urandom) & ~29'h7);
            start_stream(b, n, 1'b0);
            wait_done("rand_done", 3000);
            check("rand_cmds", 64'(acc_cnt), 64'(n));
            check("rand_samples", 64'(smp_cnt), 64'(n * SPL));
`ifdef STREAMER_UNDERRUN_CNT_EN
            check("underrun", 64'(underrun_cnt), 64'(uc));
`endif
            tick();
        end

        // Consumer backpressure: only the buffer depth worth of reads may issue
        lat = 2;
        rdy_pct = 100;
        srdy_pct = 100;
        srdy_hold = 1'b1;
        start_stream(ADDR_W'($urandom) & ~29'h7, 8, 1'b0);
        repeat (100) tick();
        check("bp_cmds", 64'(acc_cnt), 64'd4);
        check("bp_app_en", 64'(app_en), 64'd0);
        check("bp_valid", 64'(sample_valid), 64'd1);
        srdy_hold = 1'b0;
        wait_done("bp_done", 1000);
        check("bp_samples", 64'(smp_cnt), 64'd128);
        tick();

        // app_rdy stall mid-stream: command must hold
        start_stream(29'h400, 6, 1'b0);
        wait_acc("stall_reach", 2, 200);
        rdy_force_low = 1'b1;
        repeat (5) tick();
        check("stall_pending", 64'(app_en), 64'd1);
        rdy_force_low = 1'b0;
        wait_done("stall_done", 500);
        check("stall_cmds", 64'(acc_cnt), 64'd6);
        tick();

        // Loop mode then stop
        start_stream(29'h0, 2, 1'b1);
        wait_acc("loop_reach", 6, 300);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        a0 = acc_cnt;
        wait_done("loop_done", 500);
        check("loop_after_stop", 64'((acc_cnt - a0) <= 1), 64'd1);
        check("loop_samples", 64'(smp_cnt), 64'(acc_cnt * SPL));
        tick();

        // Zero-length stream
        a0 = acc_cnt;
        start_stream(29'h40, 0, 1'b0);
        check("zero_done", 64'(done), 64'd1);
        check("zero_busy", 64'(busy), 64'd0);
        tick();
        check("zero_done_clear", 64'(done), 64'd0);
        check("zero_no_cmd", 64'(acc_cnt), 64'd0);

        // Start before calibration completes
        init_calib_complete = 1'b0;
        start_stream(29'h800, 2, 1'b0);
        repeat (10) tick();
        check("cal_app_en", 64'(app_en), 64'd0);
        check("cal_busy", 64'(busy), 64'd1);
        check("cal_cmds", 64'(acc_cnt), 64'd0);
        init_calib_complete = 1'b1;
        wait_done("cal_done", 300);
        check("cal_cmds_after", 64'(acc_cnt), 64'd2);
        tick();

        // Reset in the middle of a burst, then a fresh stream
        srdy_pct = 50;
        start_stream(29'h1000, 8, 1'b0);
        wait_acc("rst_reach", 3, 300);
        ui_clk_sync_rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        tick();
        tick();
        ui_clk_sync_rst = 1'b0;
        exp_q.delete();
        repeat (10) tick();
        check("post_rst_valid", 64'(sample_valid), 64'd0);
        check("post_rst_busy", 64'(busy), 64'd0);
        start_stream(29'h2000, 2, 1'b0);
        wait_done("post_rst_done", 500);
        check("post_rst_cmds", 64'(acc_cnt), 64'd2);
        check("post_rst_samples", 64'(smp_cnt), 64'd32);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
